skewed_delay_bank: RTL

A parametrised multi-channel delay bank. Each channel is a register chain with a valid tag, and its depth grows linearly with channel index. The block skews the rows or columns of an operand into the systolic multiply array, or deskews its results on the way out. It adds stall, flush, zero-fill of empty slots and an empty flag, which a bare register chain does not have.

---
 rtl/skewed_delay_bank.sv | 53 +++++
 1 files changed

// File: rtl/skewed_delay_bank.sv
// Multi-channel delay bank: channel k is a valid-tagged register chain whose depth
// grows linearly with k (or with C-1-k when DIR=1), used to skew/deskew systolic operands.
module skewed_delay_bank #(
   parameter int W    = 16,
   parameter int C    = 4,
   parameter int BASE = 1,
   parameter int STEP = 1,
   parameter int DIR  = 0
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic           en,
   input  logic           flush,
   input  logic           in_valid,
   input  logic [C*W-1:0] in_data,
   output logic [C-1:0]   out_valid,
   output logic [C*W-1:0] out_data,
   output logic           empty
);

   logic [C-1:0] chan_busy;

   for (genvar k = 0; k < C; k++) begin : g_chan
      localparam int D = (DIR == 0) ? BASE + k * STEP : BASE + (C - 1 - k) * STEP;

      logic [D-1:0] vld;
      logic [W-1:0] dat [D];

      // Empty slots carry zero data, so an invalid output word always reads as 0.
      always_ff @(posedge Clock) begin
         if (Reset || flush) begin
            vld <= '0;
            for (int i = 0; i < D; i++) begin
               dat[i] <= '0;
            end
         end else if (en) begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data[k*W +: W] : '0;
            for (int i = 1; i < D; i++) begin
               vld[i] <= vld[i-1];
               dat[i] <= dat[i-1];
            end
         end
      end

      assign out_valid[k]        = vld[D-1];
      assign out_data[k*W +: W]  = dat[D-1];
      assign chan_busy[k]        = |vld;
   end

   assign empty = ~|chan_busy;

endmodule
